// File: rtl/mem_arbiter.sv
// Two-client round-robin memory arbiter with an in-order tag FIFO that routes responses back to the requester.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority for client 1 (data).
package mem_arbiter_pkg;
    typedef struct packed {
        logic [3:0]  byte_en;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH = 2
) (
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  cli0_put_enable,
    input  mem_op cli0_put_request,
    output logic  cli0_put_ready,
    input  logic  cli0_get_enable,
    output logic  cli0_get_ready,
    output mem_op cli0_get_response,
    input  logic  cli1_put_enable,
    input  mem_op cli1_put_request,
    output logic  cli1_put_ready,
    input  logic  cli1_get_enable,
    output logic  cli1_get_ready,
    output mem_op cli1_get_response,
    output logic  mem_put_enable,
    output mem_op mem_put_request,
    input  logic  mem_put_ready,
    output logic  mem_get_enable,
    input  logic  mem_get_ready,
    input  mem_op mem_get_response
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(TAG_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic          tag_q [TAG_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          head_id, head_get_ready, pop, eligible, grant, winner;

    // Everything handshake-related is gated by RST_N so outputs drop as soon as reset asserts.
    always_comb begin
        head_id        = tag_q[rd_ptr_q];
        head_get_ready = RST_N && mem_get_ready && (count_q != '0);
        pop            = head_get_ready && (head_id ? cli1_get_enable : cli0_get_enable);
        eligible       = RST_N && mem_put_ready && ((count_q != CNT_FULL) || pop);
        grant          = eligible && (cli0_put_enable || cli1_put_enable);
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb winner = cli1_put_enable;
`else
    logic rr_ptr_q, rr_ptr_d;

    // Preferred client wins if it asks; pointer then moves to whoever lost.
    always_comb begin
        winner   = rr_ptr_q ? cli1_put_enable : !cli0_put_enable;
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = !winner;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        cli0_put_ready    = grant && !winner;
        cli1_put_ready    = grant && winner;
        mem_put_enable    = grant;
        mem_put_request   = winner ? cli1_put_request : cli0_put_request;
        cli0_get_ready    = head_get_ready && !head_id;
        cli1_get_ready    = head_get_ready && head_id;
        cli0_get_response = mem_get_response;
        cli1_get_response = mem_get_response;
        mem_get_enable    = pop;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (grant) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (grant && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !grant) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag contents need no reset: count_q alone decides which entries are live.
    always_ff @(posedge CLK) begin
        if (grant) tag_q[wr_ptr_q] <= winner;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference arbiter/tag model predicts handshakes and response routing each cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int D = 2;

    logic  CLK = 1'b0;
    logic  RST_N = 1'b0;
    logic  cli0_put_enable, cli1_put_enable, cli0_get_enable, cli1_get_enable;
    mem_op cli0_put_request, cli1_put_request;
    logic  cli0_put_ready, cli1_put_ready, cli0_get_ready, cli1_get_ready;
    mem_op cli0_get_response, cli1_get_response;
    logic  mem_put_enable, mem_put_ready, mem_get_enable, mem_get_ready;
    mem_op mem_put_request, mem_get_response;

    mem_arbiter #(.TAG_DEPTH(D)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cli0_put_enable(cli0_put_enable), .cli0_put_request(cli0_put_request), .cli0_put_ready(cli0_put_ready),
        .cli0_get_enable(cli0_get_enable), .cli0_get_ready(cli0_get_ready), .cli0_get_response(cli0_get_response),
        .cli1_put_enable(cli1_put_enable), .cli1_put_request(cli1_put_request), .cli1_put_ready(cli1_put_ready),
        .cli1_get_enable(cli1_get_enable), .cli1_get_ready(cli1_get_ready), .cli1_get_response(cli1_get_response),
        .mem_put_enable(mem_put_enable), .mem_put_request(mem_put_request), .mem_put_ready(mem_put_ready),
        .mem_get_enable(mem_get_enable), .mem_get_ready(mem_get_ready), .mem_get_response(mem_get_response)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic  id;
        mem_op resp;
    } exp_t;

    exp_t  exp_q[$];
    mem_op mem_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  rr_m = 1'b0;
    logic  mem_ready_en = 1'b0;
    logic  force_bogus = 1'b0;
    logic  last_grant, last_win, last_pop;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic mem_op xform(input mem_op r);
        mem_op o;
        o = r;
        o.data = ~r.data ^ r.addr;
        return o;
    endfunction

    // One clock: predict and check at negedge, then update model/memory after posedge.
    task automatic tick();
        logic  head, gr0, gr1, pop, elig, win, anyp, pr0, pr1, act_put, act_get;
        mem_op wreq, act_req;
        @(negedge CLK);
        head = (exp_q.size() != 0) ? exp_q[0].id : 1'b0;
        gr0  = mem_get_ready && (exp_q.size() != 0) && !head;
        gr1  = mem_get_ready && (exp_q.size() != 0) && head;
        pop  = (gr0 && cli0_get_enable) || (gr1 && cli1_get_enable);
        elig = mem_put_ready && ((exp_q.size() < D) || pop);
        anyp = cli0_put_enable || cli1_put_enable;
`ifdef MEM_ARB_FIXED_PRIO_EN
        win = cli1_put_enable;
`else
        win = rr_m ? cli1_put_enable : !cli0_put_enable;
`endif
        pr0  = elig && anyp && !win;
        pr1  = elig && anyp && win;
        wreq = win ? cli1_put_request : cli0_put_request;
        check("cli0_put_ready", cli0_put_ready, pr0);
        check("cli1_put_ready", cli1_put_ready, pr1);
        check("mem_put_enable", mem_put_enable, pr0 || pr1);
        check("cli0_get_ready", cli0_get_ready, gr0);
        check("cli1_get_ready", cli1_get_ready, gr1);
        check("mem_get_enable", mem_get_enable, pop);
        if (pr0 || pr1) begin
            check("mem_put_request", mem_put_request, wreq);
            $display("put  cli%0d addr=%08h data=%08h", win, wreq.addr, wreq.data);
        end
        if (pop) begin
            check("get_response", gr1 ? cli1_get_response : cli0_get_response, exp_q[0].resp);
            $display("get  cli%0d addr=%08h data=%08h", head, exp_q[0].resp.addr, exp_q[0].resp.data);
        end
        last_grant = pr0 || pr1;
        last_win   = win;
        last_pop   = pop;
        act_put    = mem_put_enable;
        act_req    = mem_put_request;
        act_get    = mem_get_enable;
        @(posedge CLK);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (last_grant) begin
            exp_q.push_back('{id: win, resp: xform(wreq)});
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_m = !win;
`endif
        end
        if (act_get && mem_q.size() != 0) void'(mem_q.pop_front());
        if (act_put) mem_q.push_back(act_req);
        mem_get_ready    = force_bogus || (mem_ready_en && mem_q.size() != 0);
        mem_get_response = (mem_q.size() != 0) ? xform(mem_q[0]) : '0;
    endtask

    task automatic drain();
        cli0_put_enable = 1'b0;
        cli1_put_enable = 1'b0;
        cli0_get_enable = 1'b1;
        cli1_get_enable = 1'b1;
        mem_put_ready   = 1'b1;
        mem_ready_en    = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_handshakes_low(input string pfx);
        check({pfx, "_cli0_put_ready"}, cli0_put_ready, 1'b0);
        check({pfx, "_cli1_put_ready"}, cli1_put_ready, 1'b0);
        check({pfx, "_cli0_get_ready"}, cli0_get_ready, 1'b0);
        check({pfx, "_cli1_get_ready"}, cli1_get_ready, 1'b0);
        check({pfx, "_mem_put_enable"}, mem_put_enable, 1'b0);
        check({pfx, "_mem_get_enable"}, mem_get_enable, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_win;
        // Reset held with every input asserted: handshakes must stay low.
        cli0_put_enable  = 1'b1;
        cli1_put_enable  = 1'b1;
        cli0_get_enable  = 1'b1;
        cli1_get_enable  = 1'b1;
        cli0_put_request = '0;
        cli1_put_request = '0;
        mem_put_ready    = 1'b1;
        mem_get_ready    = 1'b1;
        mem_get_response = '0;
        #12;
        check_handshakes_low("rst");
        @(posedge CLK);
        #1;
        cli0_put_enable = 1'b0;
        cli1_put_enable = 1'b0;
        mem_get_ready   = 1'b0;
        RST_N           = 1'b1;
        tick();
        tick();

        // Both clients requesting every cycle.
        mem_ready_en     = 1'b1;
        cli0_put_request = '{byte_en: 4'hF, addr: 32'h100, data: 32'h1111_0000};
        cli1_put_request = '{byte_en: 4'h3, addr: 32'h200, data: 32'h2222_0000};
        cli0_put_enable  = 1'b1;
        cli1_put_enable  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_win = 1'b1;
`else
            exp_win = (i % 2) == 1;
`endif
            check("order_grant", last_grant, 1'b1);
            check("order_winner", last_win, exp_win);
        end
        drain();

        // Fill the tag FIFO, confirm blocking, then push and pop together.
        cli0_put_enable = 1'b1;
        cli0_get_enable = 1'b0;
        cli1_get_enable = 1'b0;
        tick();
        tick();
        tick();
        check("full_block", cli0_put_ready, 1'b0);
        cli0_get_enable = 1'b1;
        tick();
        check("pushpop_grant", last_grant, 1'b1);
        check("pushpop_pop", last_pop, 1'b1);
        cli0_get_enable = 1'b0;
        tick();
        check("still_full", last_grant, 1'b0);
        drain();

        // Head belongs to client 1 which stalls; client 0 must wait.
        cli0_get_enable = 1'b0;
        cli1_get_enable = 1'b0;
        cli1_put_enable = 1'b1;
        tick();
        cli1_put_enable = 1'b0;
        cli0_put_enable = 1'b1;
        tick();
        cli0_put_enable = 1'b0;
        cli0_get_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_cli0_get_ready", cli0_get_ready, 1'b0);
        end
        drain();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cli0_put_enable  = 1'($urandom_range(0, 1));
            cli1_put_enable  = 1'($urandom_range(0, 1));
            cli0_get_enable  = 1'($urandom_range(0, 1));
            cli1_get_enable  = 1'($urandom_range(0, 1));
            mem_put_ready    = ($urandom_range(0, 3) != 0);
            mem_ready_en     = ($urandom_range(0, 3) != 0);
            cli0_put_request = '{byte_en: 4'($urandom), addr: $urandom, data: $urandom};
            cli1_put_request = '{byte_en: 4'($urandom), addr: $urandom, data: $urandom};
            tick();
        end
        drain();

        // Asynchronous reset mid-operation with two tags outstanding.
        cli0_put_enable = 1'b1;
        cli0_get_enable = 1'b0;
        cli1_get_enable = 1'b0;
        tick();
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        check_handshakes_low("arst");
        exp_q.delete();
        mem_q.delete();
        rr_m = 1'b0;
        @(posedge CLK);
        #1;
        RST_N            = 1'b1;
        cli0_put_enable  = 1'b0;
        cli0_get_enable  = 1'b1;
        cli1_get_enable  = 1'b1;
        force_bogus      = 1'b1;
        mem_get_ready    = 1'b1;
        mem_get_response = '{byte_en: 4'h5, addr: 32'hDEAD_BEEF, data: 32'h1234_5678};
        tick();
        tick();
        force_bogus = 1'b0;
        mem_get_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TAG_DEPTH, default 2, number of in-flight requests tracked for response routing (power of two, >=2).
REQ-002 Port: CLK  input  1  sole clock, all state on posedge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Ports: cli0_put_enable / cli1_put_enable  input  1  client 0 (instruction) / client 1 (data) request valid.
REQ-005 Ports: cli0_put_request / cli1_put_request  input  mem_op  request {byte_en[3:0], addr[31:0], data[31:0]}.
REQ-006 Ports: cli0_put_ready / cli1_put_ready  output  1  request accepted this cycle when enable also high.
REQ-007 Ports: cli0_get_enable / cli1_get_enable  input  1  client consumes its response.
REQ-008 Ports: cli0_get_ready / cli1_get_ready  output  1  response valid for that client.
REQ-009 Ports: cli0_get_response / cli1_get_response  output  mem_op  response payload.
REQ-010 Ports: mem_put_enable  output  1; mem_put_request  output  mem_op; mem_put_ready  input  1  downstream memory request channel.
REQ-011 Ports: mem_get_enable  output  1; mem_get_ready  input  1; mem_get_response  input  mem_op  downstream memory response channel.

Function
REQ-012 Tag FIFO: TAG_DEPTH entries x 1 bit (client id), rd/wr pointers of log2(TAG_DEPTH) bits wrapping modulo TAG_DEPTH, count of log2(TAG_DEPTH)+1 bits.
REQ-013 Arbitration eligible only when mem_put_ready=1 and FIFO not full, or full with a pop in the same cycle.
REQ-014 Round-robin: one-bit rr_ptr names preferred client; preferred wins if enabled, else the other; rr_ptr flips to the loser's id on every grant.
REQ-015 cliN_put_ready = eligible AND cliN is the winner; at most one cliN_put_ready high per cycle; ready may depend on put_enable.
REQ-016 mem_put_enable = grant; mem_put_request = winner's request, passed through unmodified, same cycle (zero latency, no request register).
REQ-017 On grant, push winner id at wr_ptr.
REQ-018 Response routing: head id H = FIFO[rd_ptr]; cliH_get_ready = mem_get_ready AND count!=0; other client's get_ready = 0.
REQ-019 cliN_get_response = mem_get_response for both clients (valid only when that get_ready high).
REQ-020 mem_get_enable = cliH_get_enable AND cliH_get_ready; pop FIFO on that condition.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance; full FIFO with pop still accepts a push.
REQ-022 mem_get_ready while count==0: no client get_ready, mem_get_enable=0 (protocol error, no state change).
REQ-023 Responses returned strictly in request order; a stalled head client blocks the other client's responses.

Reset
REQ-024 RST_N low asynchronously clears count, rd_ptr, wr_ptr to 0 and rr_ptr to 0 (client 0 preferred).
REQ-025 While RST_N low all outputs 1-bit handshakes (cliN_put_ready, cliN_get_ready, mem_put_enable, mem_get_enable) SHALL be 0.
REQ-026 Reset mid-operation discards all tracked tags; downstream memory is reset by the same RST_N.

Configuration
REQ-027 Macro MEM_ARB_FIXED_PRIO_EN: when defined, client 1 (data) always wins when both enabled and rr_ptr is unused/constant; when undefined, round-robin per REQ-014.

Verification
REQ-028 Reset, both clients idle -> all readies 0, mem_put_enable 0, count 0.
REQ-029 Both enabled, cli0 addr 0x100, cli1 addr 0x200, mem_put_ready=1 each cycle, round-robin -> grants cli0, cli1, cli0 on consecutive cycles; responses delivered to cli0, cli1, cli0 in that order.
REQ-030 Same stimulus with MEM_ARB_FIXED_PRIO_EN -> cli1 granted every cycle, cli0_put_ready stays 0.
REQ-031 TAG_DEPTH=2, two grants, no get_enable -> third request blocked (put_ready 0); assert cli0_get_enable in cycle of third request -> pop and push same cycle, count stays 2.
REQ-032 Head tag cli1, cli1_get_enable=0 for 5 cycles, cli0_get_enable=1 -> cli0_get_ready 0 throughout, mem_get_enable 0, no pop.
REQ-033 RST_N driven low with count=2 between clock edges -> count 0 immediately, all handshake outputs 0 before next CLK edge.
